// File: rtl/mux_rr_nxnbit.sv
// NUM_CH-input registered arbitrating mux with valid/ready handshakes.
// Round-robin or fixed-priority grant feeding a one-stage output register.
module mux_rr_nxnbit #(
  parameter  int BUS_WIDTH = 8,
  parameter  int NUM_CH    = 4,
  parameter  int RR_MODE   = 1,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic                 r_valid;
  logic [BUS_WIDTH-1:0] r_data;
  logic [CH_W-1:0]      r_ch;
  logic [CH_W-1:0]      r_rr_ptr;

  logic                 w_load;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_found;
  logic [CH_W-1:0]      w_start;
  logic [CH_W-1:0]      w_grant;
  logic [CH_W-1:0]      w_next_ptr;
  logic [CH_W:0]        w_sum;
  logic [BUS_WIDTH-1:0] w_sel;

  assign w_load   = ~r_valid | out_ready;
  assign w_any    = |in_valid;
  assign w_accept = w_load & w_any;
  assign w_start  = (RR_MODE != 0) ? r_rr_ptr : '0;

  // Scan upward from the start index, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, w_start} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH))
        w_sum = w_sum - (CH_W+1)'(NUM_CH);
      if (!w_found && in_valid[w_sum[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[CH_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_grant == CH_W'(NUM_CH-1)) ?
                      '0 : w_grant + 1'b1;

  assign w_sel = in_data[w_grant*BUS_WIDTH +: BUS_WIDTH];

  assign in_ready = (w_accept & reset_n) ?
                    (NUM_CH'(1) << w_grant) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ch     <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_sel;
      r_ch    <= w_grant;
      if (RR_MODE != 0)
        r_rr_ptr <= w_next_ptr;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_rr_nxnbit.sv
// Scoreboard bench for mux_rr_nxnbit: round-robin and fixed-priority
// instances driven by directed and random traffic against a queue model.
module tb_mux_rr_nxnbit;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data   [2];
  logic [3:0]  in_valid  [2];
  logic [3:0]  in_ready  [2];
  logic [7:0]  out_data  [2];
  logic [1:0]  out_ch    [2];
  logic        out_valid [2];
  logic        out_ready [2];

  int   checks = 0;
  int   errors = 0;
  int   ptr [2];
  bit   mv  [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  mux_rr_nxnbit #(.BUS_WIDTH(8), .NUM_CH(4), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_ch(out_ch[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0])
  );

  mux_rr_nxnbit #(.BUS_WIDTH(8), .NUM_CH(4), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_ch(out_ch[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1])
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic pop_chk(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out%0d: got ch %0d data %0h expected none",
               d, out_ch[d], out_data[d]);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("out_ch%0d", d), 32'(out_ch[d]), 32'(e.ch));
    chk($sformatf("out_data%0d", d), 32'(out_data[d]), 32'(e.data));
  endtask

  // Monitor: a word leaves whenever out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++)
        if (out_valid[d] && out_ready[d])
          pop_chk(d);
    end
  end

  // Drive one cycle; model predicts grant and pushes the expected word.
  task automatic drive(input int d, input logic [3:0] v,
                       input logic [31:0] data, input logic ordy,
                       output int acc);
    bit         load;
    int         g;
    int         start;
    logic [3:0] exp_rdy;
    exp_t       e;
    in_valid[d]  = v;
    in_data[d]   = data;
    out_ready[d] = ordy;
    @(negedge clk);
    load  = !mv[d] || ordy;
    start = (d == 0) ? ptr[d] : 0;
    g     = -1;
    for (int k = 0; k < 4; k++)
      if (g < 0 && v[(start + k) % 4]) g = (start + k) % 4;
    exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk($sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(exp_rdy));
    chk($sformatf("out_valid%0d", d), 32'(out_valid[d]), 32'(mv[d]));
    acc = -1;
    if (load && g >= 0) begin
      e.ch   = g;
      e.data = data[g*8 +: 8];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      mv[d] = 1'b1;
      if (d == 0) ptr[d] = (g + 1) % 4;
      acc = g;
    end else if (load) begin
      mv[d] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int d, input int n);
    logic [3:0]  v;
    logic [31:0] data;
    int          seq [4];
    int          acc;
    v    = '0;
    data = '0;
    for (int c = 0; c < 4; c++) seq[c] = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++)
        if (!v[c] && $urandom_range(0, 2) != 0) begin
          v[c] = 1'b1;
          data[c*8 +: 8] = 8'((c << 6) | (seq[c] & 63));
          seq[c]++;
        end
      drive(d, v, data, $urandom_range(0, 3) != 0, acc);
      if (acc >= 0) v[acc] = 1'b0;
    end
    for (int i = 0; i < 3; i++) drive(d, 4'b0, 32'b0, 1'b1, acc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          acc;
    logic [7:0]  held;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 4'b0;
      in_data[d]   = 32'b0;
      out_ready[d] = 1'b1;
      ptr[d]       = 0;
      mv[d]        = 1'b0;
    end
    in_valid[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    in_valid[0] = 4'b0;
    rst_n = 1'b1;

    // Single channel
    drive(0, 4'b0100, 32'h00A5_0000, 1'b1, acc);
    drive(0, 4'b0000, 32'h0, 1'b1, acc);

    // Wrap: pointer sits at 3 after the ch2 grant
    drive(0, 4'b0011, 32'h0000_2120, 1'b1, acc);
    drive(0, 4'b0011, 32'h0000_2120, 1'b1, acc);
    drive(0, 4'b0000, 32'h0, 1'b1, acc);

    // Backpressure then same-cycle drain and load
    drive(0, 4'hF, 32'h4342_4140, 1'b1, acc);
    held = out_data[0];
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'hF, 32'h4342_4140, 1'b0, acc);
      chk("hold_data", 32'(out_data[0]), 32'(held));
    end
    drive(0, 4'hF, 32'h4342_4140, 1'b1, acc);
    drive(0, 4'hF, 32'h4342_4140, 1'b0, acc);

    // Async reset mid-stream with a word held
    chk("pre_rst_valid", 32'(out_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_data", 32'(out_data[0]), 32'd0);
    chk("rst_ch", 32'(out_ch[0]), 32'd0);
    chk("rst_ready", 32'(in_ready[0]), 32'd0);
    q0.delete();
    mv[0]  = 1'b0;
    ptr[0] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin over all channels from ch0
    for (int i = 0; i < 8; i++)
      drive(0, 4'hF, 32'h1312_1110, 1'b1, acc);
    drive(0, 4'b0, 32'h0, 1'b1, acc);

    // Fixed priority
    for (int i = 0; i < 4; i++)
      drive(1, 4'hF, 32'h1312_1110, 1'b1, acc);
    drive(1, 4'b0, 32'h0, 1'b1, acc);

    random_run(0, 1500);
    random_run(1, 500);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
